// File: rtl/dfe_bit_deframer.sv
// Bit-stream deframer for the DFE decision output: sync-word search with flywheel,
// MSB-first byte packing, and a small output FIFO toward the MAC.
module dfe_bit_deframer #(
    parameter logic [15:0] SYNC_WORD   = 16'hA5F0,
    parameter int          SYNC_TOL    = 1,
    parameter int          FRAME_BYTES = 32,
    parameter int          MISS_MAX    = 2,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [7:0] byte_out,
    output logic       byte_sof,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       locked,
    output logic       overrun
);
    localparam int BCW = $clog2(FRAME_BYTES + 1);
    localparam int MW  = $clog2(MISS_MAX + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {SEARCH, LOCKED, CHECK} state_t;

    state_t          state;
    logic [15:0]     sreg;
    logic [15:0]     cand;
    logic [4:0]      errs;
    logic            sync_ok;
    logic [2:0]      bitcnt;
    logic [BCW-1:0]  bytecnt;
    logic [MW-1:0]   miss;
    logic [3:0]      chkcnt;
    logic            sof_pend;

    // Sync compare uses the window that includes the bit arriving this clk.
    always_comb begin
        cand = {sreg[14:0], bit_in};
        errs = '0;
        for (int i = 0; i < 16; i++) begin
            errs = errs + {4'b0, cand[i] ^ SYNC_WORD[i]};
        end
        sync_ok = (errs <= 5'(SYNC_TOL));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SEARCH;
            sreg     <= '0;
            bitcnt   <= '0;
            bytecnt  <= '0;
            miss     <= '0;
            chkcnt   <= '0;
            sof_pend <= 1'b0;
        end else if (bit_valid) begin
            sreg <= cand;
            case (state)
                SEARCH: begin
                    if (sync_ok) begin
                        state    <= LOCKED;
                        bitcnt   <= '0;
                        bytecnt  <= '0;
                        miss     <= '0;
                        sof_pend <= 1'b1;
                    end
                end
                LOCKED: begin
                    bitcnt <= bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
                        sof_pend <= 1'b0;
                        if (bytecnt == BCW'(FRAME_BYTES - 1)) begin
                            state   <= CHECK;
                            bytecnt <= '0;
                            chkcnt  <= '0;
                        end else begin
                            bytecnt <= bytecnt + BCW'(1);
                        end
                    end
                end
                CHECK: begin
                    chkcnt <= chkcnt + 4'd1;
                    if (chkcnt == 4'd15) begin
                        bitcnt  <= '0;
                        bytecnt <= '0;
                        if (sync_ok) begin
                            miss     <= '0;
                            state    <= LOCKED;
                            sof_pend <= 1'b1;
                        end else if ((miss + MW'(1)) == MW'(MISS_MAX)) begin
                            miss  <= '0;
                            state <= SEARCH;
                        end else begin
                            // Flywheel: trust the frame timing through a bad sync.
                            miss     <= miss + MW'(1);
                            state    <= LOCKED;
                            sof_pend <= 1'b1;
                        end
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

    assign locked = (state != SEARCH);

    // byte_valid/byte_ready: the head entry transfers on any rising clk where both
    // are high; byte_out/byte_sof stay stable while byte_valid is high and unaccepted.
    logic [8:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic [8:0]  head, last;
    logic        full, empty, wr_req, wr_en, rd_en;

    assign full   = (count == (AW+1)'(FIFO_DEPTH));
    assign empty  = (count == '0);
    assign wr_req = bit_valid && (state == LOCKED) && (bitcnt == 3'd7);
    assign rd_en  = !empty && byte_ready;
    assign wr_en  = wr_req && (!full || rd_en);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {sof_pend, sreg[6:0], bit_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            last    <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
                last   <= head;
            end
            if (wr_en && !rd_en) begin
                count <= count + (AW+1)'(1);
            end else if (!wr_en && rd_en) begin
                count <= count - (AW+1)'(1);
            end
            overrun <= wr_req && full && !rd_en;
        end
    end

    // When empty the outputs repeat the most recently consumed entry.
    assign byte_valid = !empty;
    assign byte_out   = empty ? last[7:0] : head[7:0];
    assign byte_sof   = empty ? last[8]   : head[8];

endmodule

// File: tb/tb_dfe_bit_deframer.sv
// Directed bench for dfe_bit_deframer with FRAME_BYTES=2, MISS_MAX=2, SYNC_TOL=1.
module tb_dfe_bit_deframer;
    logic       clk = 1'b0;
    logic       reset, bit_in, bit_valid, byte_ready;
    logic [7:0] byte_out;
    logic       byte_sof, byte_valid, locked, overrun;

    int n_checks = 0;
    int n_pass   = 0;
    int ovr_cnt  = 0;
    logic [8:0] exp_q[$];
    logic [8:0] mon_exp;

    typedef struct {
        logic [15:0] sync;
        logic [15:0] payload;
        logic        exp_lock;
        logic [7:0]  exp_b0;
        logic [7:0]  exp_b1;
    } vec_t;
    vec_t vecs[6];

    dfe_bit_deframer #(
        .SYNC_WORD(16'hA5F0), .SYNC_TOL(1), .FRAME_BYTES(2), .MISS_MAX(2), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .byte_out(byte_out), .byte_sof(byte_sof), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .locked(locked), .overrun(overrun)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // scoreboard: every accepted byte is compared against the expected queue
    always @(negedge clk) begin
        if (!reset) begin
            if (overrun) ovr_cnt++;
            if (byte_valid && byte_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_byte: got sof=%0b byte=%h expected none", byte_sof, byte_out);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("byte", {7'b0, byte_sof, byte_out}, {7'b0, mon_exp});
                end
            end
        end
    end

    // drivers
    task automatic send_bits(input logic [15:0] w, input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            bit_in    = w[15-i];
            bit_valid = 1'b1;
            @(posedge clk); #1;
            if (gap) begin
                bit_valid = 1'b0;
                bit_in    = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
        end
        bit_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        bit_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        ovr_cnt = 0;
    endtask

    task automatic push_frame(input logic [15:0] p);
        exp_q.push_back({1'b1, p[15:8]});
        exp_q.push_back({1'b0, p[7:0]});
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_left", 16'(exp_q.size()), 16'd0);
    endtask

    initial begin
        reset = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; byte_ready = 1'b1;
        @(posedge clk); #1;
        check("rst_valid",   16'(byte_valid), 16'd0);
        check("rst_locked",  16'(locked),     16'd0);
        check("rst_overrun", 16'(overrun),    16'd0);
        check("rst_byte",    16'(byte_out),   16'd0);
        check("rst_sof",     16'(byte_sof),   16'd0);
        reset = 1'b0;

        vecs[0] = '{16'hA5F0, 16'h3C81, 1'b1, 8'h3C, 8'h81};
        vecs[1] = '{16'hA5F1, 16'h1234, 1'b1, 8'h12, 8'h34};
        vecs[2] = '{16'hA4F1, 16'h0000, 1'b0, 8'h00, 8'h00};
        vecs[3] = '{16'h25F0, 16'hFF00, 1'b1, 8'hFF, 8'h00};
        vecs[4] = '{16'hA5E0, 16'hA55A, 1'b1, 8'hA5, 8'h5A};
        vecs[5] = '{16'h5A0F, 16'h0000, 1'b0, 8'h00, 8'h00};

        foreach (vecs[v]) begin
            do_reset();
            byte_ready = 1'b1;
            send_bits(vecs[v].sync, 15, 1'b0);
            check("pre_lock", 16'(locked), 16'd0);
            send_bits(vecs[v].sync << 15, 1, 1'b0);
            check("lock", 16'(locked), 16'(vecs[v].exp_lock));
            if (vecs[v].exp_lock) begin
                exp_q.push_back({1'b1, vecs[v].exp_b0});
                exp_q.push_back({1'b0, vecs[v].exp_b1});
            end
            send_bits(vecs[v].payload, 7, 1'b0);
            check("byte_lat_pre", 16'(byte_valid), 16'd0);
            send_bits(vecs[v].payload << 7, 1, 1'b0);
            check("byte_lat", 16'(byte_valid), 16'(vecs[v].exp_lock));
            send_bits(vecs[v].payload << 8, 8, 1'b0);
            wait_drain();
            check("lock_hold", 16'(locked), 16'(vecs[v].exp_lock));
        end

        // flywheel through one bad sync, lose lock on two in a row
        do_reset();
        byte_ready = 1'b1;
        send_bits(16'hA5F0, 16, 1'b0);
        push_frame(16'h1122); send_bits(16'h1122, 16, 1'b0);
        send_bits(16'h0000, 16, 1'b0);
        check("fly_lock1", 16'(locked), 16'd1);
        push_frame(16'h3344); send_bits(16'h3344, 16, 1'b0);
        send_bits(16'hA5F0, 16, 1'b0);
        push_frame(16'h5566); send_bits(16'h5566, 16, 1'b0);
        send_bits(16'h0000, 16, 1'b0);
        check("fly_lock2", 16'(locked), 16'd1);
        push_frame(16'h7788); send_bits(16'h7788, 16, 1'b0);
        send_bits(16'h0000, 15, 1'b0);
        check("fly_pre_loss", 16'(locked), 16'd1);
        send_bits(16'h0000, 1, 1'b0);
        check("fly_loss", 16'(locked), 16'd0);
        wait_drain();
        check("fly_overrun", 16'(ovr_cnt), 16'd0);

        // FIFO overflow with consumer stalled, then drain and stay aligned
        do_reset();
        byte_ready = 1'b0;
        send_bits(16'hA5F0, 16, 1'b0);
        push_frame(16'hAABB); send_bits(16'hAABB, 16, 1'b0);
        send_bits(16'hA5F0, 16, 1'b0);
        push_frame(16'hCCDD); send_bits(16'hCCDD, 16, 1'b0);
        send_bits(16'hA5F0, 16, 1'b0);
        send_bits(16'hEE11, 16, 1'b0);
        idle(2);
        check("ovr_count", 16'(ovr_cnt), 16'd2);
        check("ovr_valid", 16'(byte_valid), 16'd1);
        check("ovr_head", {7'b0, byte_sof, byte_out}, {7'b0, 1'b1, 8'hAA});
        byte_ready = 1'b1;
        wait_drain();
        check("ovr_empty", 16'(byte_valid), 16'd0);
        push_frame(16'h2233);
        send_bits(16'hA5F0, 16, 1'b0);
        send_bits(16'h2233, 16, 1'b0);
        wait_drain();
        check("ovr_locked", 16'(locked), 16'd1);
        check("ovr_count2", 16'(ovr_cnt), 16'd2);

        // half-rate input with junk on idle cycles
        do_reset();
        byte_ready = 1'b1;
        send_bits(16'hA5F0, 15, 1'b1);
        check("gap_pre_lock", 16'(locked), 16'd0);
        send_bits(16'hA5F0 << 15, 1, 1'b1);
        check("gap_lock", 16'(locked), 16'd1);
        push_frame(16'h3C81);
        send_bits(16'h3C81, 16, 1'b1);
        wait_drain();

        // reset mid-frame with bytes queued
        do_reset();
        byte_ready = 1'b0;
        send_bits(16'hA5F0, 16, 1'b0);
        send_bits(16'h3C81, 16, 1'b0);
        send_bits(16'hA5F0, 16, 1'b0);
        send_bits(16'hF0F0, 12, 1'b0);
        check("mid_valid", 16'(byte_valid), 16'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_valid",  16'(byte_valid), 16'd0);
        check("mid_rst_locked", 16'(locked),     16'd0);
        check("mid_rst_byte",   16'(byte_out),   16'd0);
        reset = 1'b0;
        exp_q.delete();
        byte_ready = 1'b1;
        send_bits(16'hA5F0, 16, 1'b0);
        check("relock", 16'(locked), 16'd1);
        push_frame(16'h5A96);
        send_bits(16'h5A96, 16, 1'b0);
        wait_drain();

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
